sprite_pixel_generator: RTL and testbench
=========================================

Name: sprite_pixel_generator

Overview:
- Per-scanline sprite output unit with 8 slots. It produces the 6-bit sprite pixel word consumed by the pixel prioritizer: {isSprite0, behindBackground, palette[1:0], pattern[1:0]}.
- Slots are loaded during HBlank by the sprite fetch logic. During visible pixels, each slot counts down its X position and then shifts out 8 pattern pixels.
- The lowest-index opaque slot wins and is presented one cycle later.

Parameters:
- NUM_SLOTS, 8, number of sprite slots; must be a power of two ≤ 8.
- LEFT_CLIP_WIDTH, 8, width in pixels of the left-edge clip window.

Ports:
- clock  in  1  system clock
- reset_N  in  1  synchronous, active-low reset
- clock_EN  in  1  pixel-rate enable; all render-side state advances only when high
- render_EN  in  1  high during visible pixels 0-255 of a rendering line
- clear_EN  in  1  makes all slots transparent (asserted at start of sprite fetch)
- load_EN  in  1  load strobe for one slot
- load_slot  in  3  slot index to load
- load_patternLow  in  8  pattern plane 0; vertical flip already applied
- load_patternHigh  in  8  pattern plane 1; vertical flip already applied
- load_attribute  in  8  OAM byte 2: [6]=hflip, [5]=behind BG, [1:0]=palette
- load_X  in  8  OAM byte 3: sprite X
- load_isSprite0  in  1  slot holds OAM sprite 0
- leftClip_EN  in  1  hide sprites in pixels 0..LEFT_CLIP_WIDTH-1
- pixelX  in  8  current pixel column
- spritePixel_OUT  out  6  {isSprite0, behindBG, palette[1:0], pattern[1:0]}

Behaviour:
- **Reset** (reset_N low at posedge): all slot patterns are 0, X counters 0, attributes 0, sprite0 flags 0, and spritePixel_OUT is 6'b0. Reset has priority over every other input, including mid-line.
- **Load:** on a posedge with load_EN high, regardless of clock_EN:
  - The slot at load_slot captures the X counter, palette, priority and sprite0 flag.
  - If hflip=1, the patterns are stored bit-reversed, so bit 0 of the input becomes the first pixel shifted out.
  - A load_slot ≥ NUM_SLOTS is ignored.
- **Clear:** clear_EN zeroes the patterns of all slots.
  - Clear and load in the same cycle: the loaded slot takes the load values; all other slots clear.
  - Load to a slot that is shifting in the same cycle: load wins.
- **Render step:** on a posedge with clock_EN=1 and render_EN=1, two things happen at once.
  - Output: spritePixel_OUT is registered from the current, pre-step state.
  - Slot update, for each slot:
    - If the counter is ≠ 0, decrement it by 1.
    - Otherwise, shift both pattern registers left by 1 with zero fill. Bit 7 is the current pixel.
    - Counters saturate at 0 and do not wrap.
- **Selection:**
  - A slot is active when its counter is 0. Its pixel is {patternHigh[7], patternLow[7]}.
  - The winner is the lowest-index active slot with a nonzero pixel.
  - Output is {sprite0 & winner is opaque, behindBG, palette, pixel} of the winner, or 6'b0 if there is no winner.
  - A front-priority sprite behind an opaque behind-priority lower-index sprite is hidden by design. The priority bit is passed through, not resolved here.
- **Left clip:** if leftClip_EN=1 and pixelX < LEFT_CLIP_WIDTH, the registered output is 6'b0. Counters and shifters still advance.
- clock_EN=1 with render_EN=0: output is registered as 6'b0 and slot state holds.
- clock_EN=0: output and render state hold; loads still apply.
- **Latency:** a sprite with X=n shows its first pixel on spritePixel_OUT after render step n+1, i.e. aligned with pixel column n in the registered stream.
- After 8 shifts a slot is all-zero and stays transparent until it is reloaded.

Test Plan:
- **Basic alignment:** reset, then load slot 0 with X=3, patLow=8'hFF, patHigh=8'h00, attr=8'h02. Run 12 render steps → outputs 0,0,0, then 8× 6'b001001, then 0.
- **Horizontal flip:** load slot 2 with X=0, patLow=8'h01, patHigh=8'h01, attr=8'h41 → first output is 6'b000111, next 7 are 0.
- **Overlap and priority:**
  - Slot 1 (X=0, opaque, attr=8'h23) and slot 4 (X=0, opaque, palette 0) → slot 1 wins, output 6'b011111 with pattern 3.
  - Make slot 1 transparent at pixel 2 → slot 4 is shown.
- **Sprite 0 flag:** load slot 0 with isSprite0=1 and pattern 8'hF0/8'h00 → bit5 is set for pixels 0-3 only; it is 0 where the slot is transparent.
- **Left clip:** leftClip_EN=1, sprite at X=4 with pattern 8'hFF → pixels 4-7 output 0, pixels 8-11 are opaque.
- **Reset and clear:** assert reset_N=0 mid-shift → next output is 0 and all slots are transparent. clear_EN together with load of slot 5 → only slot 5 renders.

Source files
------------

// File: rtl/sprite_pixel_generator_if.sv
// Sprite pixel generator bus: render controls, slot-load strobe and the
// registered 6-bit sprite pixel word. The fetch/render side drives it through
// the master modport; the pixel generator consumes it through the slave
// modport.
interface sprite_pixel_generator_if;

    // Render-side timing controls
    logic       clock_EN;
    logic       render_EN;
    logic       clear_EN;
    logic       leftClip_EN;
    logic [7:0] pixelX;

    // Slot load bus from the sprite fetch logic
    logic       load_EN;
    logic [2:0] load_slot;
    logic [7:0] load_patternLow;
    logic [7:0] load_patternHigh;
    logic [7:0] load_attribute;
    logic [7:0] load_X;
    logic       load_isSprite0;

    // Output word {isSprite0, behindBG, palette[1:0], pattern[1:0]}
    logic [5:0] spritePixel_OUT;

    modport master (
        output clock_EN, render_EN, clear_EN, leftClip_EN, pixelX,
        output load_EN, load_slot, load_patternLow, load_patternHigh,
        output load_attribute, load_X, load_isSprite0,
        input  spritePixel_OUT
    );

    modport slave (
        input  clock_EN, render_EN, clear_EN, leftClip_EN, pixelX,
        input  load_EN, load_slot, load_patternLow, load_patternHigh,
        input  load_attribute, load_X, load_isSprite0,
        output spritePixel_OUT
    );

endinterface

// File: rtl/sprite_pixel_generator.sv
// Per-scanline sprite output unit. Each slot holds one sprite row: an X
// down-counter followed by two 8-bit pattern shifters. Slots are loaded during
// HBlank. During visible pixels every slot counts down and then shifts out
// eight pixels. The lowest-index opaque slot wins, and its pixel word is
// registered so it appears one render step after the slot state that
// produced it.
module sprite_pixel_generator #(
    parameter int NUM_SLOTS       = 8,
    parameter int LEFT_CLIP_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset_N,
    sprite_pixel_generator_if.slave     bus
);

    // Slots are indexed by a 3-bit load_slot, so at most eight can exist.
    initial begin : param_check
        if (NUM_SLOTS < 1 || NUM_SLOTS > 8 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0)
            $fatal(1, "NUM_SLOTS must be a power of two no larger than 8");
    end

    // Mirror a pattern byte so that input bit 0 becomes the first pixel out.
    function automatic logic [7:0] bit_reverse(input logic [7:0] value);
        logic [7:0] result;
        for (int b = 0; b < 8; b++) begin
            result[b] = value[7 - b];
        end
        return result;
    endfunction

    // Per-slot state
    logic [7:0] pattern_low  [NUM_SLOTS];
    logic [7:0] pattern_high [NUM_SLOTS];
    logic [7:0] x_count      [NUM_SLOTS];
    logic [1:0] palette      [NUM_SLOTS];
    logic       behind_bg    [NUM_SLOTS];
    logic       is_sprite0   [NUM_SLOTS];

    // Registered output word
    logic [5:0] pixel_out_q;

    // Render step qualifier: slots advance and the output is refreshed.
    logic render_step;
    logic in_clip_window;

    // Combinational winner of the current (pre-step) slot state
    logic       win_found;
    logic [5:0] win_word;

    assign render_step    = bus.clock_EN && bus.render_EN;
    assign in_clip_window = bus.leftClip_EN && (32'(bus.pixelX) < LEFT_CLIP_WIDTH);

    // Pick the lowest-index active slot whose current pixel is nonzero.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_word  = 6'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!win_found && x_count[i] == 8'd0 &&
                {pattern_high[i][7], pattern_low[i][7]} != 2'b00) begin
                win_found = 1'b1;
                win_word  = {is_sprite0[i], behind_bg[i], palette[i],
                             pattern_high[i][7], pattern_low[i][7]};
            end
        end
    end

    // Slot state: reset, load (highest priority after reset), clear, render step.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every slot
        // samples the same pre-edge values, whatever the statement order.
        if (!reset_N) begin
            // NOTE: the slot arrays are small register files, not RAM, and the
            // line must come up transparent after reset, so they are cleared
            // explicitly here.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pattern_low[i]  <= 8'h00;
                pattern_high[i] <= 8'h00;
                x_count[i]      <= 8'h00;
                palette[i]      <= 2'b00;
                behind_bg[i]    <= 1'b0;
                is_sprite0[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (bus.load_EN && bus.load_slot == 3'(i)) begin
                    // A load replaces the whole slot, overriding clear and shift.
                    x_count[i]    <= bus.load_X;
                    palette[i]    <= bus.load_attribute[1:0];
                    behind_bg[i]  <= bus.load_attribute[5];
                    is_sprite0[i] <= bus.load_isSprite0;
                    if (bus.load_attribute[6]) begin
                        pattern_low[i]  <= bit_reverse(bus.load_patternLow);
                        pattern_high[i] <= bit_reverse(bus.load_patternHigh);
                    end else begin
                        pattern_low[i]  <= bus.load_patternLow;
                        pattern_high[i] <= bus.load_patternHigh;
                    end
                end else begin
                    // Patterns: clear wins over shifting; shift only once the
                    // slot has reached its X position.
                    if (bus.clear_EN) begin
                        pattern_low[i]  <= 8'h00;
                        pattern_high[i] <= 8'h00;
                    end else if (render_step && x_count[i] == 8'd0) begin
                        pattern_low[i]  <= {pattern_low[i][6:0], 1'b0};
                        pattern_high[i] <= {pattern_high[i][6:0], 1'b0};
                    end
                    // X counter saturates at zero.
                    if (render_step && x_count[i] != 8'd0) begin
                        x_count[i] <= x_count[i] - 8'd1;
                    end
                end
            end
        end
    end

    // Output register: refreshed from the pre-step winner on each render
    // step, forced transparent inside the left clip window or outside the
    // visible area, held while clock_EN is low.
    always_ff @(posedge clock) begin
        if (!reset_N) begin
            pixel_out_q <= 6'b0;
        end else if (render_step) begin
            pixel_out_q <= in_clip_window ? 6'b0 : win_word;
        end else if (bus.clock_EN) begin
            pixel_out_q <= 6'b0;
        end
    end

    assign bus.spritePixel_OUT = pixel_out_q;

endmodule

// File: tb/tb_sprite_pixel_generator.sv
// Directed bench for sprite_pixel_generator: alignment, horizontal flip,
// slot priority, sprite-0 flag, left clip, enable gating, reset and clear.
module tb_sprite_pixel_generator;

    logic clock;
    logic reset_N;

    int vectors     = 0;
    int miscompares = 0;

    sprite_pixel_generator_if bus ();

    sprite_pixel_generator #(
        .NUM_SLOTS       (8),
        .LEFT_CLIP_WIDTH (8)
    ) dut (
        .clock   (clock),
        .reset_N (reset_N),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [5:0] expected);
        vectors++;
        assert (bus.spritePixel_OUT === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%b expected=%b", tag, bus.spritePixel_OUT, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [2:0] slot, input logic [7:0] x,
                        input logic [7:0] lo, input logic [7:0] hi,
                        input logic [7:0] attr, input logic s0);
        bus.load_EN          = 1'b1;
        bus.load_slot        = slot;
        bus.load_X           = x;
        bus.load_patternLow  = lo;
        bus.load_patternHigh = hi;
        bus.load_attribute   = attr;
        bus.load_isSprite0   = s0;
        tick();
        bus.load_EN          = 1'b0;
    endtask

    task automatic clear_all();
        bus.clear_EN = 1'b1;
        tick();
        bus.clear_EN = 1'b0;
    endtask

    task automatic render(input logic [7:0] px);
        bus.clock_EN  = 1'b1;
        bus.render_EN = 1'b1;
        bus.pixelX    = px;
        tick();
        bus.clock_EN  = 1'b0;
        bus.render_EN = 1'b0;
    endtask

    initial begin
        reset_N              = 1'b0;
        bus.clock_EN         = 1'b0;
        bus.render_EN        = 1'b0;
        bus.clear_EN         = 1'b0;
        bus.leftClip_EN      = 1'b0;
        bus.pixelX           = 8'd0;
        bus.load_EN          = 1'b0;
        bus.load_slot        = 3'd0;
        bus.load_patternLow  = 8'h00;
        bus.load_patternHigh = 8'h00;
        bus.load_attribute   = 8'h00;
        bus.load_X           = 8'h00;
        bus.load_isSprite0   = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_out", 6'b0);
        reset_N = 1'b1;
        render(8'd0);
        check("reset_slots_transparent", 6'b0);

        // Basic alignment: X=3, 8 opaque pixels of palette 2 pattern 1
        load(3'd0, 8'd3, 8'hFF, 8'h00, 8'h02, 1'b0);
        for (int i = 0; i < 12; i++) begin
            render(8'(i));
            check($sformatf("align_px%0d", i),
                  (i >= 3 && i <= 10) ? 6'b001001 : 6'b000000);
        end

        // Horizontal flip: input bit 0 is the first pixel out
        clear_all();
        load(3'd2, 8'd0, 8'h01, 8'h01, 8'h41, 1'b0);
        render(8'd0);
        check("hflip_px0", 6'b000111);
        for (int i = 1; i < 8; i++) begin
            render(8'(i));
            check($sformatf("hflip_px%0d", i), 6'b000000);
        end

        // Priority: slot 1 (behind, palette 3, pattern 3) over slot 4
        clear_all();
        load(3'd1, 8'd0, 8'hC0, 8'hC0, 8'h23, 1'b0);
        load(3'd4, 8'd0, 8'hFF, 8'h00, 8'h00, 1'b0);
        render(8'd0);
        check("prio_px0_slot1", 6'b011111);
        // clock_EN low: output and slot state hold
        bus.render_EN = 1'b1;
        tick();
        bus.render_EN = 1'b0;
        check("prio_hold_clock_en_low", 6'b011111);
        // clock_EN high, render_EN low: output zero, state holds
        bus.clock_EN = 1'b1;
        tick();
        bus.clock_EN = 1'b0;
        check("prio_render_off_zero", 6'b000000);
        render(8'd1);
        check("prio_px1_slot1", 6'b011111);
        render(8'd2);
        check("prio_px2_slot4", 6'b000001);
        render(8'd3);
        check("prio_px3_slot4", 6'b000001);

        // Sprite 0 flag only where the slot is opaque
        clear_all();
        load(3'd0, 8'd0, 8'hF0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            render(8'(i));
            check($sformatf("spr0_px%0d", i), (i < 4) ? 6'b100001 : 6'b000000);
        end

        // Left clip: X=4, pixels 4-7 hidden, 8-11 visible
        clear_all();
        load(3'd0, 8'd4, 8'hFF, 8'h00, 8'h00, 1'b0);
        bus.leftClip_EN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            render(8'(i));
            check($sformatf("clip_px%0d", i), (i >= 8) ? 6'b000001 : 6'b000000);
        end
        bus.leftClip_EN = 1'b0;

        // Reset mid-shift has priority over a render step
        clear_all();
        load(3'd0, 8'd0, 8'hFF, 8'hFF, 8'h03, 1'b0);
        render(8'd0);
        check("rst_pre_px0", 6'b001111);
        reset_N       = 1'b0;
        bus.clock_EN  = 1'b1;
        bus.render_EN = 1'b1;
        tick();
        bus.clock_EN  = 1'b0;
        bus.render_EN = 1'b0;
        reset_N       = 1'b1;
        check("rst_out_zero", 6'b000000);
        for (int i = 1; i < 4; i++) begin
            render(8'(i));
            check($sformatf("rst_slots_px%0d", i), 6'b000000);
        end

        // Clear together with load of slot 5: only slot 5 renders
        load(3'd3, 8'd0, 8'hFF, 8'h00, 8'h02, 1'b0);
        load(3'd6, 8'd0, 8'h00, 8'hFF, 8'h03, 1'b0);
        bus.clear_EN = 1'b1;
        load(3'd5, 8'd0, 8'hFF, 8'h00, 8'h01, 1'b0);
        bus.clear_EN = 1'b0;
        for (int i = 0; i < 9; i++) begin
            render(8'(i + 8));
            check($sformatf("clrload_px%0d", i), (i < 8) ? 6'b000101 : 6'b000000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
